mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter and stall controller for the pipelined MIPS core. It shares one unified instruction/data RAM port between the IF-stage fetch requester and the MEM-stage load/store requester, and sequences each access through a req/ack handshake with variable memory latency. It generates the PC and pipeline stall signals that hold the core until the access completes.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending (used only with ARB_STARVE_GUARD_EN)

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- If_Req  in  1  fetch request; held until If_Valid or If_Flush
- If_Addr  in  ADDR_W  fetch address (PC), stable while If_Req is high
- If_Flush  in  1  discard the outstanding fetch result (branch taken)
- If_Data  out  DATA_W  fetched instruction, registered
- If_Valid  out  1  one-cycle pulse: If_Data valid
- Mem_Read, Mem_Write  in  1 each  load/store request; mutually exclusive; held until Mem_Done
- Mem_Addr  in  ADDR_W  data address
- Mem_Wdata  in  DATA_W  store data
- Mem_Rdata  out  DATA_W  load data, registered
- Mem_Done  out  1  one-cycle pulse: data access complete
- Ram_Req  out  1  memory request, registered
- Ram_We  out  1  write enable, registered
- Ram_Addr  out  ADDR_W  registered, stable while Ram_Req is high
- Ram_Wdata  out  DATA_W  registered, stable while Ram_Req is high
- Ram_Rdata  in  DATA_W  read data, valid with Ram_Ack
- Ram_Ack  in  1  access complete; ignored while Ram_Req is low
- Pc_Stall  out  1  hold PC
- IF_ID_Stall  out  1  hold the IF/ID register
- Mem_Stall  out  1  hold the whole pipeline while a data access is pending

## Operation
- States: IDLE, FETCH, DATA.
- IDLE arbitration:
  - Mem_Read or Mem_Write high → DATA.
  - Otherwise, If_Req high → FETCH.
  - Otherwise, remain in IDLE.
  - Data has fixed priority.
- On grant, the Ram_* registers latch address, write data and write enable (Ram_We = Mem_Write for DATA, 0 for FETCH). Ram_Req = 1 while the state is FETCH or DATA.
- FETCH + Ram_Ack:
  - If_Data ← Ram_Rdata.
  - If_Valid pulses, unless a flush was recorded during this transaction (If_Flush sampled high in any FETCH cycle, including the ack cycle). A flushed fetch completes on the RAM but produces no If_Valid.
  - Next state is IDLE.
- DATA + Ram_Ack:
  - Mem_Done pulses.
  - On a read, Mem_Rdata ← Ram_Rdata. On a write, Mem_Rdata holds its value.
  - Next state is IDLE.
- An access always returns to IDLE after its ack, so a completed requester is never re-granted on stale inputs.
- Stalls (combinational, forced 0 while Reset is high):
  - Pc_Stall = IF_ID_Stall = (If_Req & ~If_Valid) | Mem_Stall.
  - Mem_Stall = (Mem_Read | Mem_Write) & ~Mem_Done.
- Reset values: state IDLE; Ram_Req, Ram_We, If_Valid, Mem_Done = 0; Ram_Addr, Ram_Wdata, If_Data, Mem_Rdata = 0; flush flag and starve counter = 0.
- Reset mid-transaction: Ram_Req drops immediately (asynchronously). The memory abandons the access. No Valid/Done pulse is produced.
- Ram_Ack while in IDLE: ignored.
- If_Flush while in IDLE: no effect.

## Timing
- Request is sampled at edge 0. Ram_Req is high in cycle 1.
- With a zero-wait memory, Ram_Ack is high in cycle 1 and If_Valid/Mem_Done is high in cycle 2. Minimum request-to-completion latency is 2 cycles.
- Each memory wait cycle adds 1 cycle of latency.
- Throughput is one access per 2 cycles (one IDLE cycle between accesses).
- Simultaneous fetch and data requests: the data access completes first. The fetch is granted in the IDLE cycle after Mem_Done, provided no new data request is present.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each DATA grant made while If_Req is high. It clears on any FETCH grant.
  - When the counter equals STARVE_LIMIT and If_Req is high, IDLE grants FETCH even if a data request is pending.
- ARB_STARVE_GUARD_EN undefined: strict data priority, and the counter is not present.

## Test plan
- Zero-wait fetch: If_Req=1, If_Addr=0x00000040, Ram_Ack tied 1, Ram_Rdata=0x8C220004 → Ram_Req high in cycle 1 with Ram_Addr=0x40; If_Valid pulses in cycle 2 with If_Data=0x8C220004; Pc_Stall is 1 in cycles 0–1 and 0 in cycle 2.
- Store with 3 wait states: Mem_Write=1, Mem_Addr=0x100, Mem_Wdata=0xDEADBEEF → Ram_We=1 and Ram_Wdata=0xDEADBEEF held for 4 cycles; Mem_Done pulses 1 cycle after Ram_Ack; Mem_Stall is 1 until then.
- Collision: If_Req and Mem_Read raised in the same cycle → data access is served first (Ram_Addr=Mem_Addr); the fetch is granted in the IDLE cycle after Mem_Done.
- Flush: If_Flush pulsed during FETCH with a 2-wait memory → Ram_Ack is consumed, no If_Valid pulse; the arbiter returns to IDLE.
- Reset mid-access: Reset asserted 1 cycle after Ram_Req rises → Ram_Req=0 and all outputs at their reset values immediately, with no completion pulse.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: Mem_Read held continuously with If_Req=1 → 4 DATA grants followed by 1 FETCH grant, repeating. Without the macro: no fetch grant occurs while Mem_Read is high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one unified RAM port between IF fetch and MEM load/store; data wins, fetch waits.
// Latency: 2 cycles request-to-If_Valid/Mem_Done with a zero-wait RAM, +1 per RAM wait cycle.
// Backpressure: requesters hold via Pc_Stall/IF_ID_Stall/Mem_Stall; RAM backpressures with Ram_Ack.
// Optional ARB_STARVE_GUARD_EN: a pending fetch wins after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              If_Req,
  input  logic [ADDR_W-1:0] If_Addr,
  input  logic              If_Flush,
  output logic [DATA_W-1:0] If_Data,
  output logic              If_Valid,
  input  logic              Mem_Read,
  input  logic              Mem_Write,
  input  logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Wdata,
  output logic [DATA_W-1:0] Mem_Rdata,
  output logic              Mem_Done,
  output logic              Ram_Req,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Wdata,
  input  logic [DATA_W-1:0] Ram_Rdata,
  input  logic              Ram_Ack,
  output logic              Pc_Stall,
  output logic              IF_ID_Stall,
  output logic              Mem_Stall
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t              state_q, state_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_done_q, mem_done_d;
  logic                flush_q, flush_d;
  logic                data_req;
  logic                starve_hit;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
`endif

  assign data_req = Mem_Read | Mem_Write;

  // Arbitration, transaction sequencing and completion pulses.
  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_data_d   = if_data_q;
    if_valid_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    flush_d     = flush_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
    starve_hit   = If_Req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));
`else
    starve_hit   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (data_req && !starve_hit) begin
          state_d     = DATA;
          ram_req_d   = 1'b1;
          ram_we_d    = Mem_Write;
          ram_addr_d  = Mem_Addr;
          ram_wdata_d = Mem_Wdata;
`ifdef ARB_STARVE_GUARD_EN
          if (If_Req) starve_cnt_d = starve_cnt_q + CNT_W'(1);
`endif
        end else if (If_Req) begin
          state_d    = FETCH;
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = If_Addr;
          flush_d    = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
          starve_cnt_d = '0;
`endif
        end
      end
      FETCH: begin
        // A flush anywhere in the transaction, ack cycle included, suppresses If_Valid.
        if (If_Flush) flush_d = 1'b1;
        if (Ram_Ack) begin
          if_data_d  = Ram_Rdata;
          if_valid_d = ~(flush_q | If_Flush);
          state_d    = IDLE;
          ram_req_d  = 1'b0;
          ram_we_d   = 1'b0;
        end
      end
      DATA: begin
        if (Ram_Ack) begin
          mem_done_d = 1'b1;
          if (!ram_we_q) mem_rdata_d = Ram_Rdata;
          state_d    = IDLE;
          ram_req_d  = 1'b0;
          ram_we_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_data_q   <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_data_q   <= if_data_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
      flush_q     <= flush_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  // Consecutive data grants taken while a fetch was waiting.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign Ram_Req   = ram_req_q;
  assign Ram_We    = ram_we_q;
  assign Ram_Addr  = ram_addr_q;
  assign Ram_Wdata = ram_wdata_q;
  assign If_Data   = if_data_q;
  assign If_Valid  = if_valid_q;
  assign Mem_Rdata = mem_rdata_q;
  assign Mem_Done  = mem_done_q;

  // Stalls release in the same cycle the completion pulse is visible.
  assign Mem_Stall   = ~Reset & data_req & ~mem_done_q;
  assign Pc_Stall    = ~Reset & ((If_Req & ~if_valid_q) | (data_req & ~mem_done_q));
  assign IF_ID_Stall = Pc_Stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized CPU/RAM environment.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// The RAM side inserts random wait states and stray acks while the port is idle.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        If_Req, If_Flush, If_Valid;
  logic [31:0] If_Addr, If_Data;
  logic        Mem_Read, Mem_Write, Mem_Done;
  logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
  logic        Ram_Req, Ram_We, Ram_Ack;
  logic [31:0] Ram_Addr, Ram_Wdata, Ram_Rdata;
  logic        Pc_Stall, IF_ID_Stall, Mem_Stall;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Reset(Reset),
    .If_Req(If_Req), .If_Addr(If_Addr), .If_Flush(If_Flush),
    .If_Data(If_Data), .If_Valid(If_Valid),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata), .Mem_Done(Mem_Done),
    .Ram_Req(Ram_Req), .Ram_We(Ram_We), .Ram_Addr(Ram_Addr), .Ram_Wdata(Ram_Wdata),
    .Ram_Rdata(Ram_Rdata), .Ram_Ack(Ram_Ack),
    .Pc_Stall(Pc_Stall), .IF_ID_Stall(IF_ID_Stall), .Mem_Stall(Mem_Stall)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference environment state (transaction level).
  logic [31:0] ram_mem [16];
  bit          in_flight, ack_given, cur_fetch, cur_flushed, cur_we;
  logic [31:0] cur_addr, cur_wdata;
  int          waits, sc;
  bit          exp_fv, exp_done;
  logic [31:0] exp_fdata, last_rdata;

  task automatic clear_inputs();
    If_Req = 0; If_Addr = 0; If_Flush = 0;
    Mem_Read = 0; Mem_Write = 0; Mem_Addr = 0; Mem_Wdata = 0;
    Ram_Ack = 0; Ram_Rdata = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    clear_inputs();
    @(negedge Clk);
    Reset = 0;
    in_flight = 0; ack_given = 0; cur_flushed = 0; waits = 0; sc = 0;
    exp_fv = 0; exp_done = 0; exp_fdata = 0; last_rdata = 0;
  endtask

  // One falling-edge step of the randomized CPU + RAM environment.
  task automatic step();
    bit fv, dn, fetch_g;
    logic ms;
    int idx;
    fv = exp_fv; dn = exp_done;
    check("if_valid", {31'b0, If_Valid}, {31'b0, fv});
    if (fv) check("if_data", If_Data, exp_fdata);
    check("mem_done", {31'b0, Mem_Done}, {31'b0, dn});
    check("mem_rdata", Mem_Rdata, last_rdata);
    ms = (Mem_Read | Mem_Write) & ~dn;
    check("mem_stall", {31'b0, Mem_Stall}, {31'b0, ms});
    check("pc_stall", {31'b0, Pc_Stall}, {31'b0, (If_Req & ~fv) | ms});
    check("ifid_stall", {31'b0, IF_ID_Stall}, {31'b0, (If_Req & ~fv) | ms});

    // RAM port: hold, drop after ack, or a fresh grant from what the last edge saw.
    if (in_flight) begin
      if (ack_given) begin
        check("ram_req_drop", {31'b0, Ram_Req}, 32'd0);
        in_flight = 0;
      end else begin
        check("ram_req_hold", {31'b0, Ram_Req}, 32'd1);
        check("ram_addr_hold", Ram_Addr, cur_addr);
        check("ram_we_hold", {31'b0, Ram_We}, {31'b0, cur_we});
      end
    end else begin
      check("ram_req_grant", {31'b0, Ram_Req}, {31'b0, If_Req | Mem_Read | Mem_Write});
      if (If_Req | Mem_Read | Mem_Write) begin
        fetch_g = If_Req && !(Mem_Read || Mem_Write);
`ifdef ARB_STARVE_GUARD_EN
        if (If_Req && sc == LIMIT) fetch_g = 1;
`endif
        if (fetch_g) begin
          cur_fetch = 1; cur_addr = If_Addr; cur_we = 0; cur_flushed = 0; sc = 0;
        end else begin
          cur_fetch = 0; cur_addr = Mem_Addr; cur_we = Mem_Write; cur_wdata = Mem_Wdata;
          if (If_Req) sc++;
          if (cur_we) check("ram_wdata", Ram_Wdata, cur_wdata);
        end
        check("ram_addr", Ram_Addr, cur_addr);
        check("ram_we", {31'b0, Ram_We}, {31'b0, cur_we});
        in_flight = 1;
        waits = $urandom_range(0, 3);
      end
    end

    // Requesters retire on their completion pulse.
    exp_fv = 0; exp_done = 0; ack_given = 0;
    if (fv) If_Req = 0;
    if (dn) begin Mem_Read = 0; Mem_Write = 0; end
    If_Flush = 0;

    // RAM responder.
    if (in_flight) begin
      if (cur_fetch && If_Req && $urandom_range(0, 5) == 0) begin
        If_Flush = 1; If_Req = 0; cur_flushed = 1;
      end
      idx = int'(cur_addr[5:2]);
      if (waits == 0) begin
        Ram_Ack = 1; ack_given = 1;
        if (cur_fetch) begin
          Ram_Rdata = ram_mem[idx]; exp_fdata = ram_mem[idx]; exp_fv = !cur_flushed;
        end else if (cur_we) begin
          ram_mem[idx] = cur_wdata; Ram_Rdata = $urandom; exp_done = 1;
        end else begin
          Ram_Rdata = ram_mem[idx]; last_rdata = ram_mem[idx]; exp_done = 1;
        end
      end else begin
        waits--; Ram_Ack = 0; Ram_Rdata = $urandom;
      end
    end else begin
      Ram_Ack = ($urandom_range(0, 3) == 0);
      Ram_Rdata = $urandom;
      If_Flush = ($urandom_range(0, 7) == 0);
    end

    // New requests.
    if (!Mem_Read && !Mem_Write && $urandom_range(0, 3) == 0) begin
      if ($urandom_range(0, 1) == 1) Mem_Write = 1; else Mem_Read = 1;
      Mem_Addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      Mem_Wdata = $urandom;
    end
    if (!If_Req && $urandom_range(0, 2) == 0) begin
      If_Req = 1;
      If_Addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
    end
  endtask

  initial begin
    int grants, fgrants;
    logic prev_req;
    Reset = 1;
    clear_inputs();
    for (int i = 0; i < 16; i++) ram_mem[i] = 32'hA000_0000 + 32'(i);
    #1;
    check("rst_ram_req", {31'b0, Ram_Req}, 32'd0);
    check("rst_ram_addr", Ram_Addr, 32'd0);
    check("rst_if_valid", {31'b0, If_Valid}, 32'd0);
    check("rst_mem_done", {31'b0, Mem_Done}, 32'd0);
    check("rst_mem_rdata", Mem_Rdata, 32'd0);

    // Zero-wait fetch.
    do_reset();
    If_Req = 1; If_Addr = 32'h40; Ram_Ack = 1; Ram_Rdata = 32'h8C22_0004;
    #1 check("zw_pc_stall_c0", {31'b0, Pc_Stall}, 32'd1);
    @(negedge Clk);
    check("zw_ram_req_c1", {31'b0, Ram_Req}, 32'd1);
    check("zw_ram_addr_c1", Ram_Addr, 32'h40);
    check("zw_pc_stall_c1", {31'b0, Pc_Stall}, 32'd1);
    @(negedge Clk);
    check("zw_if_valid_c2", {31'b0, If_Valid}, 32'd1);
    check("zw_if_data_c2", If_Data, 32'h8C22_0004);
    check("zw_pc_stall_c2", {31'b0, Pc_Stall}, 32'd0);
    If_Req = 0; Ram_Ack = 0;
    @(negedge Clk);
    check("zw_if_valid_c3", {31'b0, If_Valid}, 32'd0);
    check("zw_ram_req_c3", {31'b0, Ram_Req}, 32'd0);

    // Continuous data traffic with a waiting fetch.
    do_reset();
    Mem_Read = 1; Mem_Addr = 32'h100; If_Req = 1; If_Addr = 32'h40; Ram_Ack = 1;
    grants = 0; fgrants = 0; prev_req = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Ram_Req && !prev_req) begin
        grants++;
        if (Ram_Addr == 32'h40) fgrants++;
      end
      prev_req = Ram_Req;
    end
    check("starve_grants", 32'(grants), 32'd20);
`ifdef ARB_STARVE_GUARD_EN
    check("starve_fetch_grants", 32'(fgrants), 32'd4);
`else
    check("starve_fetch_grants", 32'(fgrants), 32'd0);
`endif

    // Reset in the middle of an access.
    do_reset();
    If_Req = 1; If_Addr = 32'h80;
    @(negedge Clk);
    check("mid_ram_req", {31'b0, Ram_Req}, 32'd1);
    @(posedge Clk);
    #1 Reset = 1;
    #1;
    check("mid_rst_ram_req", {31'b0, Ram_Req}, 32'd0);
    check("mid_rst_ram_addr", Ram_Addr, 32'd0);
    check("mid_rst_pc_stall", {31'b0, Pc_Stall}, 32'd0);
    @(negedge Clk);
    clear_inputs(); Ram_Ack = 1;
    Reset = 0;
    @(negedge Clk);
    check("mid_no_valid", {31'b0, If_Valid}, 32'd0);
    check("mid_idle_ack", {31'b0, Ram_Req}, 32'd0);

    // Randomized traffic against the reference environment.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
